mem_stage_nb: RTL and testbench

//  Non-blocking MEM stage: an in-order queue of up to DEPTH in-flight instructions between EX and WB.

---
 rtl/mem_stage_nb_pkg.sv | 26 ++
 rtl/mem_stage_nb_align.sv | 47 ++++
 rtl/mem_stage_nb.sv | 177 +++++++++++++++++
 tb/tb_mem_stage_nb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_nb_pkg.sv
// Shared definitions for the non-blocking MEM stage: load-op bit indices,
// default payload width and the per-entry EX->MEM field layout.
package mem_stage_nb_pkg;

  localparam int unsigned PAY_W_DEF = 64;
  localparam int unsigned LD_OP_W   = 7;

  // one-hot ld_op = {lw,lb,lbu,lh,lhu,lwl,lwr}
  localparam int unsigned LD_LW  = 6;
  localparam int unsigned LD_LB  = 5;
  localparam int unsigned LD_LBU = 4;
  localparam int unsigned LD_LH  = 3;
  localparam int unsigned LD_LHU = 2;
  localparam int unsigned LD_LWL = 1;
  localparam int unsigned LD_LWR = 0;

  typedef struct packed {
    logic               load;
    logic [LD_OP_W-1:0] ld_op;
    logic [1:0]         addr_lo;
    logic [31:0]        rt_value;
    logic               gr_we;
    logic [4:0]         dest;
  } es_to_ms_t;

endpackage

// File: rtl/mem_stage_nb_align.sv
// Load data alignment: byte/half extraction with sign or zero extension,
// and the lwl/lwr partial-word merge with the old rt value.
module mem_load_align
  import mem_stage_nb_pkg::*;
(
  input  logic [LD_OP_W-1:0] ld_op,
  input  logic [1:0]         addr_lo,
  input  logic [31:0]        rt_value,
  input  logic [31:0]        rdata,
  output logic [31:0]        result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result   = '0;
    if (ld_op[LD_LW]) begin
      result = rdata;
    end else if (ld_op[LD_LB]) begin
      result = {{24{byte_sel[7]}}, byte_sel};
    end else if (ld_op[LD_LBU]) begin
      result = {24'h0, byte_sel};
    end else if (ld_op[LD_LH]) begin
      result = addr_lo[0] ? '0 : {{16{half_sel[15]}}, half_sel};
    end else if (ld_op[LD_LHU]) begin
      result = addr_lo[0] ? '0 : {16'h0, half_sel};
    end else if (ld_op[LD_LWL]) begin
      case (addr_lo)
        2'd0:    result = {rdata[7:0],  rt_value[23:0]};
        2'd1:    result = {rdata[15:0], rt_value[15:0]};
        2'd2:    result = {rdata[23:0], rt_value[7:0]};
        default: result = rdata;
      endcase
    end else if (ld_op[LD_LWR]) begin
      case (addr_lo)
        2'd0:    result = rdata;
        2'd1:    result = {rt_value[31:24], rdata[31:8]};
        2'd2:    result = {rt_value[31:16], rdata[31:16]};
        default: result = {rt_value[31:8],  rdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_nb.sv
// Non-blocking MEM stage: in-order queue of in-flight instructions, in-order
// load response fill, flush with late-response cancel, hazard/forward lookup.
module mem_stage_nb
  import mem_stage_nb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PAY_W = PAY_W_DEF,
  parameter int unsigned CNT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               es_to_ms_valid,
  output logic               ms_allowin,
  input  logic [PAY_W-1:0]   es_payload,
  input  logic               es_load,
  input  logic [6:0]         es_ld_op,
  input  logic [1:0]         es_addr_lo,
  input  logic [31:0]        es_rt_value,
  input  logic               es_gr_we,
  input  logic [4:0]         es_dest,
  input  logic [31:0]        es_result,
  input  logic               data_sram_data_ok,
  input  logic [31:0]        data_sram_rdata,
  input  logic               flush,
  output logic               ms_to_ws_valid,
  input  logic               ws_allowin,
  output logic [PAY_W-1:0]   ms_to_ws_payload,
  output logic               ms_to_ws_gr_we,
  output logic [4:0]         ms_to_ws_dest,
  output logic [31:0]        ms_to_ws_result,
  output logic [31:0]        ms_busy_regs,
  input  logic [4:0]         fwd_raddr0,
  input  logic [4:0]         fwd_raddr1,
  output logic               fwd_hit0,
  output logic               fwd_hit1,
  output logic               fwd_ready0,
  output logic               fwd_ready1,
  output logic [31:0]        fwd_data0,
  output logic [31:0]        fwd_data1,
  output logic               ms_empty
);

  localparam int unsigned    PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(DEPTH);

  es_to_ms_t          meta_q    [DEPTH];
  logic [31:0]        result_q  [DEPTH];
  logic [PAY_W-1:0]   payload_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, done_q;
  logic [PTR_W-1:0]   head, tail, rsp_ptr, sidx, fidx;
  logic [PTR_W:0]     count;
  logic [CNT_W-1:0]   cancel_cnt, cancel_nxt, n_pend;
  logic               pend_any, push, pop, fill, drop;
  logic [31:0]        align_data;

  assign ms_to_ws_valid   = valid_q[head] & done_q[head] & ~flush;
  assign pop              = ms_to_ws_valid & ws_allowin;
  assign ms_allowin       = (count < FULL) | pop;
  assign push             = es_to_ms_valid & ms_allowin & ~flush;
  assign ms_to_ws_payload = payload_q[head];
  assign ms_to_ws_gr_we   = meta_q[head].gr_we;
  assign ms_to_ws_dest    = meta_q[head].dest;
  assign ms_to_ws_result  = result_q[head];
  assign ms_empty         = (count == '0) && (cancel_cnt == '0);

  // Responses return in issue order, so the first pending load from head is the one being answered.
  always_comb begin
    sidx     = '0;
    rsp_ptr  = '0;
    pend_any = 1'b0;
    n_pend   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sidx = head + PTR_W'(i);
      if (valid_q[sidx] && meta_q[sidx].load && !done_q[sidx]) begin
        if (!pend_any) rsp_ptr = sidx;
        pend_any = 1'b1;
        n_pend   = n_pend + CNT_W'(1);
      end
    end
  end

  assign drop = data_sram_data_ok & (cancel_cnt != '0);
  assign fill = data_sram_data_ok & (cancel_cnt == '0) & pend_any;

  always_comb begin
    cancel_nxt = cancel_cnt;
    if (drop) cancel_nxt = cancel_nxt - CNT_W'(1);
    if (flush) begin
      cancel_nxt = cancel_nxt + n_pend;
      if (fill) cancel_nxt = cancel_nxt - CNT_W'(1);
    end
  end

  mem_load_align u_align (
    .ld_op    (meta_q[rsp_ptr].ld_op),
    .addr_lo  (meta_q[rsp_ptr].addr_lo),
    .rt_value (meta_q[rsp_ptr].rt_value),
    .rdata    (data_sram_rdata),
    .result   (align_data)
  );

  // Scan oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    fidx         = '0;
    ms_busy_regs = '0;
    fwd_hit0     = 1'b0;
    fwd_ready0   = 1'b0;
    fwd_data0    = '0;
    fwd_hit1     = 1'b0;
    fwd_ready1   = 1'b0;
    fwd_data1    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fidx = head + PTR_W'(i);
      if (valid_q[fidx] && meta_q[fidx].gr_we) begin
        if (!done_q[fidx]) ms_busy_regs[meta_q[fidx].dest] = 1'b1;
        if (fwd_raddr0 != 5'd0 && meta_q[fidx].dest == fwd_raddr0) begin
          fwd_hit0   = 1'b1;
          fwd_ready0 = done_q[fidx];
          fwd_data0  = result_q[fidx];
        end
        if (fwd_raddr1 != 5'd0 && meta_q[fidx].dest == fwd_raddr1) begin
          fwd_hit1   = 1'b1;
          fwd_ready1 = done_q[fidx];
          fwd_data1  = result_q[fidx];
        end
      end
    end
    ms_busy_regs[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      cancel_cnt <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        meta_q[i]    <= '0;
        result_q[i]  <= '0;
        payload_q[i] <= '0;
      end
    end else begin
      cancel_cnt <= cancel_nxt;
      if (flush) begin
        valid_q <= '0;
        tail    <= head;
        count   <= '0;
      end else begin
        if (pop) begin
          valid_q[head] <= 1'b0;
          head          <= head + PTR_W'(1);
        end
        if (push) begin
          valid_q[tail]   <= 1'b1;
          done_q[tail]    <= ~es_load;
          meta_q[tail]    <= '{load: es_load, ld_op: es_ld_op, addr_lo: es_addr_lo,
                               rt_value: es_rt_value, gr_we: es_gr_we, dest: es_dest};
          result_q[tail]  <= es_result;
          payload_q[tail] <= es_payload;
          tail            <= tail + PTR_W'(1);
        end
        if (fill) begin
          done_q[rsp_ptr]   <= 1'b1;
          result_q[rsp_ptr] <= align_data;
        end
        case ({push, pop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_nb.sv
// Directed self-checking bench for mem_stage_nb.
module tb_mem_stage_nb;

  localparam logic [6:0] OP_LW  = 7'b1000000;
  localparam logic [6:0] OP_LB  = 7'b0100000;
  localparam logic [6:0] OP_LBU = 7'b0010000;
  localparam logic [6:0] OP_LH  = 7'b0001000;
  localparam logic [6:0] OP_LHU = 7'b0000100;
  localparam logic [6:0] OP_LWL = 7'b0000010;
  localparam logic [6:0] OP_LWR = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid, ms_allowin;
  logic [63:0] es_payload;
  logic        es_load;
  logic [6:0]  es_ld_op;
  logic [1:0]  es_addr_lo;
  logic [31:0] es_rt_value;
  logic        es_gr_we;
  logic [4:0]  es_dest;
  logic [31:0] es_result;
  logic        data_ok;
  logic [31:0] rdata;
  logic        flush;
  logic        ms_to_ws_valid, ws_allowin;
  logic [63:0] ms_to_ws_payload;
  logic        ms_to_ws_gr_we;
  logic [4:0]  ms_to_ws_dest;
  logic [31:0] ms_to_ws_result, ms_busy_regs;
  logic [4:0]  fwd_raddr0, fwd_raddr1;
  logic        fwd_hit0, fwd_hit1, fwd_ready0, fwd_ready1;
  logic [31:0] fwd_data0, fwd_data1;
  logic        ms_empty;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_nb #(.DEPTH(4), .PAY_W(64), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_payload(es_payload), .es_load(es_load), .es_ld_op(es_ld_op),
    .es_addr_lo(es_addr_lo), .es_rt_value(es_rt_value), .es_gr_we(es_gr_we),
    .es_dest(es_dest), .es_result(es_result),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .flush(flush),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_to_ws_payload(ms_to_ws_payload), .ms_to_ws_gr_we(ms_to_ws_gr_we),
    .ms_to_ws_dest(ms_to_ws_dest), .ms_to_ws_result(ms_to_ws_result),
    .ms_busy_regs(ms_busy_regs),
    .fwd_raddr0(fwd_raddr0), .fwd_raddr1(fwd_raddr1),
    .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
    .fwd_ready0(fwd_ready0), .fwd_ready1(fwd_ready1),
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1),
    .ms_empty(ms_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ld, input logic [6:0] op, input logic [1:0] lo,
                      input logic [31:0] rt, input logic [4:0] dst, input logic [31:0] res);
    es_to_ms_valid = 1'b1;
    es_load        = ld;
    es_ld_op       = op;
    es_addr_lo     = lo;
    es_rt_value    = rt;
    es_gr_we       = 1'b1;
    es_dest        = dst;
    es_result      = res;
    es_payload     = {32'hC0DE_0000, 27'h0, dst};
    tick();
    es_to_ms_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; es_to_ms_valid = 0; es_payload = '0; es_load = 0; es_ld_op = '0;
    es_addr_lo = '0; es_rt_value = '0; es_gr_we = 0; es_dest = '0; es_result = '0;
    data_ok = 0; rdata = '0; flush = 0; ws_allowin = 1; fwd_raddr0 = '0; fwd_raddr1 = '0;
    tick(); tick();
    checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL rst_allowin got=%0h exp=1", ms_allowin); end
    checks++; if (ms_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%0h exp=1", ms_empty); end
    checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", ms_to_ws_valid); end
    checks++; if (ms_busy_regs !== 32'h0) begin failures++; $display("FAIL rst_busy got=%h exp=0", ms_busy_regs); end
    checks++; if (ms_to_ws_result !== 32'h0) begin failures++; $display("FAIL rst_result got=%h exp=0", ms_to_ws_result); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    fwd_raddr0 = 5'd3;
    push(1, OP_LW, 2'd0, 32'h0, 5'd3, 32'h0);
    checks++; if (ms_busy_regs !== 32'h8) begin failures++; $display("FAIL t1_busy got=%h exp=00000008", ms_busy_regs); end
    checks++; if ({fwd_hit0, fwd_ready0} !== 2'b10) begin failures++; $display("FAIL t1_fwd_pend got=%b exp=10", {fwd_hit0, fwd_ready0}); end
    checks++; if (ms_empty !== 1'b0) begin failures++; $display("FAIL t1_empty got=%0h exp=0", ms_empty); end
    tick();
    data_ok = 1; rdata = 32'h8765_4321; #1;
    checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL t1_no_comb got=%0h exp=0", ms_to_ws_valid); end
    tick();
    data_ok = 0; #1;
    checks++; if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL t1_valid got=%0h exp=1", ms_to_ws_valid); end
    checks++; if (ms_to_ws_result !== 32'h8765_4321) begin failures++; $display("FAIL t1_result got=%h exp=87654321", ms_to_ws_result); end
    checks++; if (ms_to_ws_payload !== 64'hC0DE_0000_0000_0003) begin failures++; $display("FAIL t1_payload got=%h exp=c0de000000000003", ms_to_ws_payload); end
    checks++; if ({fwd_ready0, fwd_data0} !== {1'b1, 32'h8765_4321}) begin failures++; $display("FAIL t1_fwd_pop got=%0h/%h exp=1/87654321", fwd_ready0, fwd_data0); end
    tick();
    checks++; if ({ms_to_ws_valid, ms_empty} !== 2'b01) begin failures++; $display("FAIL t1_drain got=%b exp=01", {ms_to_ws_valid, ms_empty}); end
  endtask

  task automatic test_lb_bypass();
    push(1, OP_LB, 2'd3, 32'h0, 5'd4, 32'h0);
    push(0, 7'd0, 2'd0, 32'h0, 5'd9, 32'h5);
    fwd_raddr0 = 5'd9; fwd_raddr1 = 5'd4; #1;
    checks++; if ({fwd_hit0, fwd_ready0, fwd_data0} !== {2'b11, 32'h5}) begin failures++; $display("FAIL t2_fwd9 got=%b/%h exp=11/00000005", {fwd_hit0, fwd_ready0}, fwd_data0); end
    checks++; if ({fwd_hit1, fwd_ready1} !== 2'b10) begin failures++; $display("FAIL t2_fwd4 got=%b exp=10", {fwd_hit1, fwd_ready1}); end
    checks++; if (ms_busy_regs !== 32'h10) begin failures++; $display("FAIL t2_busy got=%h exp=00000010", ms_busy_regs); end
    checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL t2_hold got=%0h exp=0", ms_to_ws_valid); end
    data_ok = 1; rdata = 32'h8012_3456;
    tick();
    data_ok = 0; #1;
    checks++; if ({ms_to_ws_valid, ms_to_ws_dest, ms_to_ws_result} !== {1'b1, 5'd4, 32'hFFFF_FF80}) begin failures++; $display("FAIL t2_lb got=%0h/%0d/%h exp=1/4/ffffff80", ms_to_ws_valid, ms_to_ws_dest, ms_to_ws_result); end
    tick();
    checks++; if ({ms_to_ws_valid, ms_to_ws_dest, ms_to_ws_result} !== {1'b1, 5'd9, 32'h5}) begin failures++; $display("FAIL t2_addu got=%0h/%0d/%h exp=1/9/00000005", ms_to_ws_valid, ms_to_ws_dest, ms_to_ws_result); end
    tick();
    checks++; if (ms_empty !== 1'b1) begin failures++; $display("FAIL t2_empty got=%0h exp=1", ms_empty); end
  endtask

  task automatic test_full_wrap();
    ws_allowin = 0;
    for (int i = 1; i <= 4; i++) push(1, OP_LW, 2'd0, 32'h0, 5'(i), 32'h0);
    checks++; if (ms_allowin !== 1'b0) begin failures++; $display("FAIL t3_full got=%0h exp=0", ms_allowin); end
    checks++; if (dut.count !== 3'd4 || dut.head !== 2'd3) begin failures++; $display("FAIL t3_state got=%0d/%0d exp=4/3", dut.count, dut.head); end
    for (int i = 1; i <= 4; i++) begin
      data_ok = 1; rdata = 32'hA000_0000 + 32'(i);
      tick();
    end
    data_ok = 0; #1;
    checks++; if ({ms_to_ws_valid, ms_allowin, ms_to_ws_result} !== {2'b10, 32'hA000_0001}) begin failures++; $display("FAIL t3_blocked got=%b/%h exp=10/a0000001", {ms_to_ws_valid, ms_allowin}, ms_to_ws_result); end
    ws_allowin = 1; #1;
    checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL t3_allow_pop got=%0h exp=1", ms_allowin); end
    push(0, 7'd0, 2'd0, 32'h0, 5'd7, 32'h77);
    checks++; if (dut.count !== 3'd4 || dut.head !== 2'd0) begin failures++; $display("FAIL t3_wrap got=%0d/%0d exp=4/0", dut.count, dut.head); end
    checks++; if ({ms_to_ws_dest, ms_to_ws_result} !== {5'd2, 32'hA000_0002}) begin failures++; $display("FAIL t3_r2 got=%0d/%h exp=2/a0000002", ms_to_ws_dest, ms_to_ws_result); end
    tick();
    checks++; if (ms_to_ws_result !== 32'hA000_0003) begin failures++; $display("FAIL t3_r3 got=%h exp=a0000003", ms_to_ws_result); end
    tick();
    checks++; if (ms_to_ws_result !== 32'hA000_0004) begin failures++; $display("FAIL t3_r4 got=%h exp=a0000004", ms_to_ws_result); end
    tick();
    checks++; if ({ms_to_ws_valid, ms_to_ws_dest, ms_to_ws_result} !== {1'b1, 5'd7, 32'h77}) begin failures++; $display("FAIL t3_r5 got=%0h/%0d/%h exp=1/7/00000077", ms_to_ws_valid, ms_to_ws_dest, ms_to_ws_result); end
    tick();
    checks++; if (ms_empty !== 1'b1) begin failures++; $display("FAIL t3_empty got=%0h exp=1", ms_empty); end
  endtask

  task automatic test_flush_cancel();
    for (int i = 5; i <= 7; i++) push(1, OP_LW, 2'd0, 32'h0, 5'(i), 32'h0);
    flush = 1; #1;
    checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL t4_flush_valid got=%0h exp=0", ms_to_ws_valid); end
    tick();
    flush = 0; #1;
    checks++; if (dut.cancel_cnt !== 3'd3 || dut.count !== 3'd0) begin failures++; $display("FAIL t4_cancel got=%0d/%0d exp=3/0", dut.cancel_cnt, dut.count); end
    checks++; if ({ms_empty, ms_busy_regs} !== {1'b0, 32'h0}) begin failures++; $display("FAIL t4_empty_busy got=%0h/%h exp=0/0", ms_empty, ms_busy_regs); end
    data_ok = 1; rdata = 32'hDEAD_BEEF;
    push(1, OP_LW, 2'd0, 32'h0, 5'd8, 32'h0);
    checks++; if (dut.cancel_cnt !== 3'd2 || ms_busy_regs !== 32'h100) begin failures++; $display("FAIL t4_drop1 got=%0d/%h exp=2/00000100", dut.cancel_cnt, ms_busy_regs); end
    tick();
    checks++; if (dut.cancel_cnt !== 3'd1) begin failures++; $display("FAIL t4_drop2 got=%0d exp=1", dut.cancel_cnt); end
    tick();
    checks++; if ({dut.cancel_cnt, ms_to_ws_valid, ms_empty} !== {3'd0, 2'b00}) begin failures++; $display("FAIL t4_drop3 got=%0d/%0h/%0h exp=0/0/0", dut.cancel_cnt, ms_to_ws_valid, ms_empty); end
    rdata = 32'hCAFE_F00D;
    tick();
    data_ok = 0; #1;
    checks++; if ({ms_to_ws_valid, ms_to_ws_dest, ms_to_ws_result} !== {1'b1, 5'd8, 32'hCAFE_F00D}) begin failures++; $display("FAIL t4_new_lw got=%0h/%0d/%h exp=1/8/cafef00d", ms_to_ws_valid, ms_to_ws_dest, ms_to_ws_result); end
    tick();
    checks++; if (ms_empty !== 1'b1) begin failures++; $display("FAIL t4_empty_end got=%0h exp=1", ms_empty); end
  endtask

  task automatic test_flush_with_fill();
    push(1, OP_LW, 2'd0, 32'h0, 5'd10, 32'h0);
    push(1, OP_LW, 2'd0, 32'h0, 5'd11, 32'h0);
    flush = 1; data_ok = 1; rdata = 32'h1111_1111;
    tick();
    flush = 0; data_ok = 0; #1;
    checks++; if ({dut.cancel_cnt, ms_empty, ms_to_ws_valid} !== {3'd1, 2'b00}) begin failures++; $display("FAIL t5_cancel got=%0d/%0h/%0h exp=1/0/0", dut.cancel_cnt, ms_empty, ms_to_ws_valid); end
    data_ok = 1;
    tick();
    data_ok = 0; #1;
    checks++; if ({dut.cancel_cnt, ms_empty} !== {3'd0, 1'b1}) begin failures++; $display("FAIL t5_drain got=%0d/%0h exp=0/1", dut.cancel_cnt, ms_empty); end
  endtask

  task automatic test_align_ops();
    logic [6:0]  ops [6] = '{OP_LBU, OP_LH, OP_LHU, OP_LH, OP_LWR, OP_LB};
    logic [1:0]  los [6] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd0};
    logic [31:0] rts [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hAABB_CCDD, 32'h0};
    logic [31:0] rds [6] = '{32'h1234_80FF, 32'h8001_1234, 32'h8001_1234, 32'h8001_1234, 32'h1122_3344, 32'h0000_007F};
    logic [31:0] exs [6] = '{32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h0, 32'hAABB_1122, 32'h0000_007F};
    for (int k = 0; k < 6; k++) begin
      push(1, ops[k], los[k], rts[k], 5'd20, 32'h0);
      data_ok = 1; rdata = rds[k];
      tick();
      data_ok = 0; #1;
      checks++; if ({ms_to_ws_valid, ms_to_ws_result} !== {1'b1, exs[k]}) begin failures++; $display("FAIL align_%0d got=%0h/%h exp=1/%h", k, ms_to_ws_valid, ms_to_ws_result, exs[k]); end
      tick();
    end
  endtask

  task automatic test_lwl_reset();
    push(1, OP_LWL, 2'd1, 32'hAABB_CCDD, 5'd12, 32'h0);
    data_ok = 1; rdata = 32'h1122_3344;
    tick();
    data_ok = 0; #1;
    checks++; if ({ms_to_ws_valid, ms_to_ws_result} !== {1'b1, 32'h3344_CCDD}) begin failures++; $display("FAIL t6_lwl got=%0h/%h exp=1/3344ccdd", ms_to_ws_valid, ms_to_ws_result); end
    tick();
    push(1, OP_LW, 2'd0, 32'h0, 5'd14, 32'h0);
    push(1, OP_LW, 2'd0, 32'h0, 5'd15, 32'h0);
    flush = 1;
    tick();
    flush = 0;
    fwd_raddr0 = 5'd13;
    push(1, OP_LW, 2'd0, 32'h0, 5'd13, 32'h0);
    checks++; if ({dut.cancel_cnt, fwd_hit0} !== {3'd2, 1'b1}) begin failures++; $display("FAIL t6_prereset got=%0d/%0h exp=2/1", dut.cancel_cnt, fwd_hit0); end
    #2;
    reset = 1; #1;
    checks++; if ({ms_to_ws_valid, ms_allowin, ms_empty, fwd_hit0} !== 4'b0110) begin failures++; $display("FAIL t6_rst_flags got=%b exp=0110", {ms_to_ws_valid, ms_allowin, ms_empty, fwd_hit0}); end
    checks++; if ({ms_busy_regs, ms_to_ws_result, ms_to_ws_dest, ms_to_ws_gr_we} !== '0) begin failures++; $display("FAIL t6_rst_data got=%h/%h/%0d/%0h exp=0", ms_busy_regs, ms_to_ws_result, ms_to_ws_dest, ms_to_ws_gr_we); end
    checks++; if ({ms_to_ws_payload, dut.cancel_cnt} !== '0) begin failures++; $display("FAIL t6_rst_cancel got=%h/%0d exp=0/0", ms_to_ws_payload, dut.cancel_cnt); end
    tick();
    reset = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_lb_bypass();
    test_full_wrap();
    test_flush_cancel();
    test_flush_with_fill();
    test_align_ops();
    test_lwl_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
